adder_serial: RTL and testbench
===============================

# adder_serial

Parametrised digit-serial adder/subtractor: adds or subtracts two WIDTH-bit operands DIGIT bits per clock, carrying between digits in a register. It is the sequential, parametrised successor to the team's combinational 4-bit ripple adder. It trades latency for a fixed DIGIT-wide full-adder chain. It adds a start/busy/done handshake, subtract mode, carry/overflow flags and board LED status.

## Interface
- WIDTH, 8, operand and result width; must be a multiple of DIGIT
- DIGIT, 2, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH
- Derived: N = WIDTH/DIGIT, the number of digit cycles per operation
- CLK  in  1  single clock, rising-edge
- RST  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- sub  in  1  0 = a+b, 1 = a−b; sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- q  out  WIDTH  result; final from the done cycle until the next accepted start
- cout  out  1  carry out of the MSB; in sub mode 1 = no borrow (a ≥ b unsigned)
- ovf  out  1  two's-complement overflow (carry into MSB xor carry out of MSB)
- busy  out  1  high while digits are being processed
- done  out  1  one-cycle pulse when q, cout and ovf are final
- LED[4:7]  out  4  active-low status: LED[4]=~busy, LED[5]=~done, LED[6]=~cout, LED[7]=~ovf

## Operation
- State machine states: IDLE, RUN, DONE. Registers: opA, opB, carry, digit counter cnt (0..N−1), q, cout, ovf.
- **IDLE or DONE with start=1:**
  - Load opA=a, opB = sub ? ~b : b, carry=sub.
  - Clear cnt, q, cout and ovf to 0.
  - Go to RUN.
- **IDLE with start=0:** stay in IDLE; all outputs hold.
- **RUN, each edge:**
  - Compute the DIGIT-bit full-adder chain on opA/opB bits [cnt·DIGIT +: DIGIT] plus carry.
  - Write the sum into q at the same slice; carry ← digit carry-out; cnt ← cnt+1.
  - Slices of q above the current digit stay 0 during RUN.
- **Last digit (cnt = N−1):**
  - Also capture cout = final carry and ovf = (carry into bit WIDTH−1) xor (carry out of bit WIDTH−1).
  - Go to DONE.
- **DONE:** lasts one cycle, done=1. Next edge: RUN if start=1 (new operands loaded), else IDLE. q, cout and ovf hold.
- **start while RUN:** ignored; no queuing; operands are not re-sampled.
- **Arithmetic:** modulo 2^WIDTH; sub performs a + ~b + 1. No saturation.
- **Reset:**
  - RST low forces immediately, with no clock needed: state=IDLE, q=0, cout=0, ovf=0, busy=0, done=0, cnt=0, LED=4'b1111.
  - An operation in progress is abandoned and not resumed after RST releases.

## Timing
- The edge that accepts start is E0.
- busy is high from after E0 through E(N−1), and low after EN.
- done and final q, cout, ovf appear after EN, so latency is N cycles from the accepting edge.
- done is high exactly one cycle.
- Back-to-back: start held high during the done cycle gives throughput of one result per N+1 cycles (accepting edge plus N digit edges).
- DIGIT=WIDTH (N=1): busy is high for one cycle, done follows the next edge.
- cout and ovf are registered together with the final q digit; there is no combinational path from inputs to outputs.
- LED is derived combinationally from registered flags, so it is glitch-free relative to CLK.

## Test plan
- **Reset (WIDTH=8, DIGIT=2):** assert RST low mid-idle → q=8'h00, cout=0, ovf=0, busy=0, done=0, LED=4'b1111 immediately.
- **Add with overflow:** start, sub=0, a=8'h3C, b=8'h45 → busy for 4 cycles, done on the 4th edge after E0, q=8'h81, cout=0, ovf=1, LED=4'b1010 during done.
- **Add wrap:** a=8'hFF, b=8'h01, sub=0 → q=8'h00, cout=1, ovf=0.
- **Subtract, no overflow:** sub=1, a=8'h10, b=8'h20 → q=8'hF0, cout=0, ovf=0.
- **Subtract with overflow:** sub=1, a=8'h80, b=8'h01 → q=8'h7F, cout=1, ovf=1.
- **Handshake:**
  - start pulses during RUN are ignored and the result is unchanged.
  - start held in the done cycle with a=8'h01, b=8'h02 → second done 4 cycles later, q=8'h03.
- **Reset mid-operation:** RST low after 2 RUN cycles → immediate reset values. After release, stays IDLE, with no done, until a new start.
- **Parameter sweep:**
  - WIDTH=4, DIGIT=1: 4'h7+4'h1 → q=4'h8, ovf=1, latency 4.
  - WIDTH=8, DIGIT=8: 8'h7F+8'h01 → q=8'h80, ovf=1, latency 1.

Source files
------------

// File: rtl/adder_serial.sv
// adder_serial: digit-serial adder/subtractor.
// Adds or subtracts two WIDTH-bit operands DIGIT bits per clock.
// The carry between digits lives in a register.
// A result takes N = WIDTH/DIGIT cycles after the accepting edge.
//
// Ports:
//   CLK, RST         rising-edge clock; asynchronous active-low reset
//   start, sub, a, b request; sampled only in IDLE or DONE
//   q, cout, ovf     result and flags, final from the done cycle onward
//   busy, done       busy while digits run; done is a one-cycle pulse
//   LED[4:7]         active-low status {~busy, ~done, ~cout, ~ovf}

// One bit of the digit-wide ripple chain.
module adder_serial_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic [4:7]       LED
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              carry_q, carry_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  // Current digit slice and its ripple chain; dc[0] is the registered carry.
  logic [31:0]       base;
  logic [DIGIT-1:0]  da, db, ds;
  logic [DIGIT:0]    dc;

  assign base  = 32'(cnt_q) * 32'(DIGIT);
  assign da    = opa_q[base +: DIGIT];
  assign db    = opb_q[base +: DIGIT];
  assign dc[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    adder_serial_fa u_fa (
      .a  (da[i]),
      .b  (db[i]),
      .ci (dc[i]),
      .s  (ds[i]),
      .co (dc[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    q_d     = q_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Subtraction as a + ~b + 1: invert b and seed the carry with 1.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          q_d     = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        q_d[base +: DIGIT] = ds;
        carry_d = dc[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // The MSB of the last digit is bit WIDTH-1 of the word.
          cout_d  = dc[DIGIT];
          ovf_d   = dc[DIGIT] ^ dc[DIGIT-1];
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      q_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      q_q     <= q_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q    = q_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign LED  = {~busy, ~done, ~cout_q, ~ovf_q};

endmodule

// File: tb/tb_adder_serial.sv
// tb_adder_serial: directed vectors for adder_serial in three sizes.
// The main instance is m (8/2); s is 4/1; w is 8/8.
module tb_adder_serial;
  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  // m: WIDTH=8 DIGIT=2
  logic       m_start = 0, m_sub = 0;
  logic [7:0] m_a = 0, m_b = 0, m_q;
  logic       m_cout, m_ovf, m_busy, m_done;
  logic [4:7] m_led;
  // s: WIDTH=4 DIGIT=1
  logic       s_start = 0, s_sub = 0;
  logic [3:0] s_a = 0, s_b = 0, s_q;
  logic       s_cout, s_ovf, s_busy, s_done;
  logic [4:7] s_led;
  // w: WIDTH=8 DIGIT=8
  logic       w_start = 0, w_sub = 0;
  logic [7:0] w_a = 0, w_b = 0, w_q;
  logic       w_cout, w_ovf, w_busy, w_done;
  logic [4:7] w_led;

  adder_serial #(.WIDTH(8), .DIGIT(2)) u_m (
    .CLK(clk), .RST(RST), .start(m_start), .sub(m_sub), .a(m_a), .b(m_b),
    .q(m_q), .cout(m_cout), .ovf(m_ovf), .busy(m_busy), .done(m_done), .LED(m_led));
  adder_serial #(.WIDTH(4), .DIGIT(1)) u_s (
    .CLK(clk), .RST(RST), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b),
    .q(s_q), .cout(s_cout), .ovf(s_ovf), .busy(s_busy), .done(s_done), .LED(s_led));
  adder_serial #(.WIDTH(8), .DIGIT(8)) u_w (
    .CLK(clk), .RST(RST), .start(w_start), .sub(w_sub), .a(w_a), .b(w_b),
    .q(w_q), .cout(w_cout), .ovf(w_ovf), .busy(w_busy), .done(w_done), .LED(w_led));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic drive(input int sel, input logic st, input logic sb,
                       input logic [7:0] av, input logic [7:0] bv);
    case (sel)
      0: begin m_start = st; m_sub = sb; m_a = av; m_b = bv; end
      1: begin s_start = st; s_sub = sb; s_a = av[3:0]; s_b = bv[3:0]; end
      default: begin w_start = st; w_sub = sb; w_a = av; w_b = bv; end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? m_done : (sel == 1) ? s_done : w_done;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? m_busy : (sel == 1) ? s_busy : w_busy;
  endfunction

  // Called at a negedge. Issues one request and returns at the negedge of
  // the done cycle (or after the cycle budget). lat counts edges after E0.
  task automatic run_op(input int sel, input logic sb, input logic [7:0] av,
                        input logic [7:0] bv, input bit glitch, input string tag,
                        output int lat, output int nb);
    drive(sel, 1'b1, sb, av, bv);
    @(negedge clk);
    drive(sel, 1'b0, sb, av, bv);
    lat = 0;
    nb  = 0;
    while (!get_done(sel) && lat < 20) begin
      if (get_busy(sel)) nb++;
      if (glitch && lat == 1) begin
        chk({tag, ".mid_q"}, m_q, 8'h01);
        drive(sel, 1'b1, sb, 8'hAA, 8'h55);
      end
      if (glitch && lat == 2) drive(sel, 1'b0, sb, 8'hAA, 8'h55);
      @(negedge clk);
      lat++;
    end
    chk({tag, ".done"}, get_done(sel), 1);
  endtask

  int lat, nb, bad;

  initial begin
    #1 RST = 1'b0;
    @(negedge clk);
    chk("rst.q", m_q, 8'h00);
    chk("rst.busy", m_busy, 0);
    chk("rst.done", m_done, 0);
    chk("rst.led", m_led, 4'b1111);
    RST = 1'b1;
    @(negedge clk);

    // 3C+45 with start/operand noise during RUN
    run_op(0, 1'b0, 8'h3C, 8'h45, 1'b1, "add_ovf", lat, nb);
    chk("add_ovf.lat", lat, 4);
    chk("add_ovf.busy_cyc", nb, 4);
    chk("add_ovf.q", m_q, 8'h81);
    chk("add_ovf.cout", m_cout, 0);
    chk("add_ovf.ovf", m_ovf, 1);
    chk("add_ovf.led", m_led, 4'b1010);
    @(negedge clk);
    chk("idle.done", m_done, 0);
    chk("idle.busy", m_busy, 0);
    chk("idle.q_hold", m_q, 8'h81);

    // asynchronous reset while idle: no clock edge before the check
    #2 RST = 1'b0;
    #1;
    chk("rst_idle.q", m_q, 8'h00);
    chk("rst_idle.ovf", m_ovf, 0);
    chk("rst_idle.led", m_led, 4'b1111);
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);

    run_op(0, 1'b1, 8'h10, 8'h20, 1'b0, "sub", lat, nb);
    chk("sub.q", m_q, 8'hF0);
    chk("sub.cout", m_cout, 0);
    chk("sub.ovf", m_ovf, 0);
    @(negedge clk);

    run_op(0, 1'b0, 8'hFF, 8'h01, 1'b0, "wrap", lat, nb);
    chk("wrap.q", m_q, 8'h00);
    chk("wrap.cout", m_cout, 1);
    chk("wrap.ovf", m_ovf, 0);
    chk("wrap.led", m_led, 4'b1001);
    // start issued inside the done cycle
    run_op(0, 1'b0, 8'h01, 8'h02, 1'b0, "b2b", lat, nb);
    chk("b2b.lat", lat, 4);
    chk("b2b.q", m_q, 8'h03);
    chk("b2b.cout", m_cout, 0);
    @(negedge clk);

    // reset after two RUN cycles
    drive(0, 1'b1, 1'b0, 8'h3C, 8'h45);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 8'h3C, 8'h45);
    repeat (2) @(negedge clk);
    chk("rst_run.busy_before", m_busy, 1);
    #2 RST = 1'b0;
    #1;
    chk("rst_run.q", m_q, 8'h00);
    chk("rst_run.busy", m_busy, 0);
    chk("rst_run.done", m_done, 0);
    chk("rst_run.led", m_led, 4'b1111);
    @(negedge clk);
    RST = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m_done || m_busy) bad++;
    end
    chk("rst_run.stays_idle", bad, 0);

    run_op(0, 1'b1, 8'h80, 8'h01, 1'b0, "sub_ovf", lat, nb);
    chk("sub_ovf.q", m_q, 8'h7F);
    chk("sub_ovf.cout", m_cout, 1);
    chk("sub_ovf.ovf", m_ovf, 1);
    @(negedge clk);

    run_op(1, 1'b0, 8'h07, 8'h01, 1'b0, "w4d1", lat, nb);
    chk("w4d1.lat", lat, 4);
    chk("w4d1.busy_cyc", nb, 4);
    chk("w4d1.q", s_q, 4'h8);
    chk("w4d1.ovf", s_ovf, 1);
    chk("w4d1.cout", s_cout, 0);
    @(negedge clk);

    run_op(2, 1'b0, 8'h7F, 8'h01, 1'b0, "w8d8", lat, nb);
    chk("w8d8.lat", lat, 1);
    chk("w8d8.busy_cyc", nb, 1);
    chk("w8d8.q", w_q, 8'h80);
    chk("w8d8.ovf", w_ovf, 1);
    chk("w8d8.cout", w_cout, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
